// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and the
// RV32I major opcodes that the control decoder also understands.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } seq_state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_IMM)    || (op == OP_AUIPC) ||
           (op == OP_STORE) || (op == OP_REG)    || (op == OP_LUI)   ||
           (op == OP_BRANCH)|| (op == OP_JALR)   || (op == OP_JAL);
  endfunction

  // Only loads and stores need a data-memory phase.
  function automatic logic is_mem_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_timer.sv
// Wait-cycle counter for the shared memory port; flags when the memory has
// stalled for MEM_TIMEOUT cycles without answering.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer around the combinational
// control decoder; gates decoder strobes into their own phase and counts retires.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int n           = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] instr,
  input  logic         mem_ready,
  input  logic         ctl_RegWEn,
  input  logic         ctl_MemRw,
  input  logic         ctl_PCSel,
  output logic         mem_req,
  output logic         mem_we,
  output logic         addr_sel,
  output logic         ir_load,
  output logic         pc_load,
  output logic         RegWEn,
  output logic         PCSel,
  output logic [2:0]   state,
  output logic         fault,
  output logic [n-1:0] instret
);

  seq_state_e   state_q;
  seq_state_e   state_d;
  logic [n-1:0] instret_q;
  logic [n-1:0] instret_d;
  logic         in_mem_phase;
  logic         timer_expired;
  logic [6:0]   opcode;
  logic         unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[n-1:7];
  assign in_mem_phase      = (state_q == ST_FETCH) || (state_q == ST_MEM);

  // Outside FETCH/MEM the counter is held at zero, so each memory phase starts fresh.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_mem_phase || mem_ready),
    .inc     (in_mem_phase && !mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // A ready in the same cycle as the timeout takes priority over the fault.
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_FAULT;
      ST_EXEC:   state_d = is_mem_opcode(opcode) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        state_d   = ST_FETCH;
        instret_d = instret_q + 1'b1;
      end
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    RegWEn   = 1'b0;
    PCSel    = 1'b0;
    fault    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = ctl_MemRw;
      end
      ST_WB: begin
        pc_load = 1'b1;
        RegWEn  = ctl_RegWEn;
        PCSel   = ctl_PCSel;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a per-instruction reference
// model expands each instruction into its expected cycle-by-cycle trace.
module tb_multicycle_sequencer;

  localparam int N           = 32;
  localparam int MEM_TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  instr = '0;
  logic          mem_ready = 1'b0;
  logic          ctl_RegWEn = 1'b0;
  logic          ctl_MemRw = 1'b0;
  logic          ctl_PCSel = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_load, pc_load, RegWEn, PCSel, fault;
  logic [2:0]    state;
  logic [N-1:0]  instret;

  multicycle_sequencer #(.n(N), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .ctl_RegWEn(ctl_RegWEn), .ctl_MemRw(ctl_MemRw), .ctl_PCSel(ctl_PCSel),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_load(pc_load), .RegWEn(RegWEn), .PCSel(PCSel), .state(state),
    .fault(fault), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic req, we, asel, irl, pcl, rwe, pcs, flt, rdy;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    logic        rwe, mrw, pcs;
    int          exp_cycles;
    logic        exp_fault;
  } vec_t;

  cyc_t         plan[$];
  bit           plan_fault;
  int           test_count = 0;
  int           fail_count = 0;
  logic [N-1:0] model_instret = '0;

  function automatic logic [10:0] dut_outputs();
    return {state, mem_req, mem_we, addr_sel, ir_load, pc_load, RegWEn, PCSel, fault};
  endfunction

  function automatic logic [10:0] exp_outputs(input cyc_t c);
    return {c.st, c.req, c.we, c.asel, c.irl, c.pcl, c.rwe, c.pcs, c.flt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_cyc(input logic [2:0] st, input logic req, we, asel, irl, pcl,
                          input logic rwe, pcs, flt, rdy);
    cyc_t c;
    c.st = st; c.req = req; c.we = we; c.asel = asel; c.irl = irl;
    c.pcl = pcl; c.rwe = rwe; c.pcs = pcs; c.flt = flt; c.rdy = rdy;
    plan.push_back(c);
  endtask

  // Reference model: one instruction becomes a list of expected cycles.
  // fw/mw are the number of wait cycles before ready; > MEM_TIMEOUT never answers.
  task automatic build_plan(input logic [31:0] ins, input int fw, input int mw,
                            input logic rwe, input logic mrw, input logic pcs);
    logic [6:0] op;
    bit legal, is_mem;
    op = ins[6:0];
    legal  = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    is_mem = (op == 7'h03) || (op == 7'h23);
    plan.delete();
    plan_fault = 0;
    if (fw > MEM_TIMEOUT) begin
      for (int k = 0; k <= MEM_TIMEOUT; k++) push_cyc(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      plan_fault = 1;
    end else begin
      for (int k = 0; k <= fw; k++)
        push_cyc(3'd1, 1, 0, 0, k == fw, 0, 0, 0, 0, k == fw);
    end
    if (!plan_fault) begin
      push_cyc(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      if (!legal) plan_fault = 1;
    end
    if (!plan_fault) begin
      push_cyc(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      if (is_mem) begin
        if (mw > MEM_TIMEOUT) begin
          for (int k = 0; k <= MEM_TIMEOUT; k++) push_cyc(3'd4, 1, mrw, 1, 0, 0, 0, 0, 0, 0);
          plan_fault = 1;
        end else begin
          for (int k = 0; k <= mw; k++) push_cyc(3'd4, 1, mrw, 1, 0, 0, 0, 0, 0, k == mw);
        end
      end
    end
    if (!plan_fault)
      push_cyc(3'd5, 0, 0, 0, 0, 1, rwe, pcs, 0, 1'($urandom_range(0, 1)));
    else
      repeat (4) push_cyc(3'd7, 0, 0, 0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
  endtask

  // Expects the DUT to be in its first FETCH cycle, just after the clock edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    int measured;
    measured = -1;
    instr = v.ins; ctl_RegWEn = v.rwe; ctl_MemRw = v.mrw; ctl_PCSel = v.pcs;
    build_plan(v.ins, v.fw, v.mw, v.rwe, v.mrw, v.pcs);
    for (int i = 0; i < plan.size(); i++) begin
      mem_ready = plan[i].rdy;
      @(negedge clk);
      checkOutput($sformatf("%s outputs cycle %0d", tag, i), 32'(dut_outputs()), 32'(exp_outputs(plan[i])));
      checkOutput($sformatf("%s instret cycle %0d", tag, i), instret, model_instret);
      if (measured < 0 && pc_load) measured = i + 1;
      if (measured < 0 && fault)   measured = i;
      if (plan[i].st == 3'd5) model_instret++;
      @(posedge clk);
      #1;
    end
    if (v.exp_cycles >= 0) begin
      checkOutput($sformatf("%s latency", tag), 32'(measured), 32'(v.exp_cycles));
      checkOutput($sformatf("%s fault", tag), 32'(fault), 32'(v.exp_fault));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("reset outputs", 32'(dut_outputs()), 32'h0);
    checkOutput("reset instret", instret, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("state after release", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("state after first clk", 32'(state), 32'd1);
    model_instret = '0;
  endtask

  vec_t        vecs[13];
  logic [6:0]  legal_ops[9]   = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
  logic [6:0]  illegal_ops[4] = '{7'h7F, 7'h00, 7'h0B, 7'h73};

  initial begin
    vec_t v;
    logic [31:0] r;
    logic [6:0]  op;

    vecs[0]  = '{32'h00400793,  0,  0, 1, 0, 0,  4, 0};
    vecs[1]  = '{32'hfef42623,  0,  3, 0, 1, 0,  8, 0};
    vecs[2]  = '{32'h00458603,  0,  0, 1, 0, 0,  5, 0};
    vecs[3]  = '{32'h00058663,  0,  0, 0, 0, 1,  4, 0};
    vecs[4]  = '{32'h0000006F,  2,  0, 1, 0, 1,  6, 0};
    vecs[5]  = '{32'h12345037,  0,  0, 1, 0, 0,  4, 0};
    vecs[6]  = '{32'h00000017,  1,  0, 1, 0, 0,  5, 0};
    vecs[7]  = '{32'h00c58533,  0,  0, 1, 0, 0,  4, 0};
    vecs[8]  = '{32'h000080e7,  0,  0, 1, 0, 1,  4, 0};
    vecs[9]  = '{32'h00400793, 15,  0, 1, 0, 0, 19, 0};
    vecs[10] = '{32'h0000007F,  0,  0, 1, 1, 1,  2, 1};
    vecs[11] = '{32'h00400793, 16,  0, 1, 0, 0, 16, 1};
    vecs[12] = '{32'h00458603,  0, 16, 1, 0, 0, 19, 1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].exp_fault) do_reset();
    end

    // Reset while a store is stalled in MEM must drop the request at once.
    instr = 32'hfef42623; ctl_MemRw = 1'b1; ctl_RegWEn = 1'b0; ctl_PCSel = 1'b0;
    v = '{32'h00400793, 0, 0, 1, 0, 0, 4, 0};
    applyStimulus(v, "pre-abort addi");
    instr = 32'hfef42623; ctl_MemRw = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid-MEM state", 32'(state), 32'd4);
    checkOutput("mid-MEM mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort state", 32'(state), 32'd0);
    checkOutput("abort instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort release state", 32'(state), 32'd0);
    @(posedge clk); #1;
    checkOutput("abort refetch state", 32'(state), 32'd1);
    model_instret = '0;

    // Randomized instruction stream against the reference model.
    for (int t = 0; t < 40; t++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) op = illegal_ops[$urandom_range(0, 3)];
      else op = legal_ops[$urandom_range(0, 8)];
      v.ins = {r[31:7], op};
      v.fw  = ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT + 1 : int'($urandom_range(0, 3));
      v.mw  = ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT + 1 : int'($urandom_range(0, 3));
      v.rwe = 1'($urandom_range(0, 1));
      v.mrw = 1'($urandom_range(0, 1));
      v.pcs = 1'($urandom_range(0, 1));
      v.exp_cycles = -1;
      v.exp_fault  = 1'b0;
      applyStimulus(v, $sformatf("rand%0d", t));
      if (plan_fault) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
